// File: rtl/abs_encoder_multi.sv
// Multi-device AD7606-class parallel-bus reader: trigger-started conversion, per-device CS readout,
// atomic frame publish. Optional BUSY timeout is built only when ABSENC_TIMEOUT_EN is defined.
module abs_encoder_multi #(
  parameter int NUM_DEV     = 2,
  parameter int CH_PER_DEV  = 8,
  parameter int DATA_W      = 16,
  parameter int RST_CYC     = 8,
  parameter int CONV_LOW    = 5,
  parameter int CS_LOW      = 1,
  parameter int CS_HIGH     = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 trig,
  input  logic                                 busy,
  input  logic [DATA_W-1:0]                    data_in,
  input  logic                                 clr_err,
  output logic                                 convst,
  output logic                                 enc_rst,
  output logic [NUM_DEV-1:0]                   cs_n,
  output logic [NUM_DEV*CH_PER_DEV*DATA_W-1:0] data_out,
  output logic                                 frame_valid,
  output logic [15:0]                          frame_cnt,
  output logic                                 overrun,
  output logic                                 err_timeout,
  output logic                                 rd_active
);

  localparam int NW    = NUM_DEV * CH_PER_DEV;
  localparam int FW    = NW * DATA_W;
  localparam int DEV_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CH_W  = (CH_PER_DEV > 1) ? $clog2(CH_PER_DEV) : 1;
  localparam int K_W   = (NW > 1) ? $clog2(NW) : 1;
  localparam int CNT_W = $clog2(RST_CYC + CONV_LOW + CS_LOW + CS_HIGH + TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_RST_HOLD, S_IDLE, S_CONV, S_WAIT, S_READ, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEV_W-1:0]  dev_q, dev_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              ph_q, ph_d;        // 0: cs low phase, 1: cs high phase
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     data_out_q, data_out_d;
  logic              fv_q, fv_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              ovr_q, ovr_d;
  logic              trig_meta_q, trig_sync_q, trig_prev_q;
  logic              busy_meta_q, busy_sync_q, busy_prev_q;
  logic              trig_rise, busy_fall, last_word, ovr_set;
  logic [K_W-1:0]    k;

  // trig is a level request: only its synchronised rising edge matters, no ready/ack is returned.
  // frame_valid is a one-cycle strobe with no backpressure; data_out holds until the next frame.
  assign trig_rise = trig_sync_q & ~trig_prev_q;
  assign busy_fall = ~busy_sync_q & busy_prev_q;
  assign last_word = (dev_q == DEV_W'(NUM_DEV - 1)) && (ch_q == CH_W'(CH_PER_DEV - 1));
  assign k         = K_W'(int'(dev_q) * CH_PER_DEV + int'(ch_q));
  assign ovr_set   = trig_rise && (state_q == S_CONV || state_q == S_WAIT ||
                                   state_q == S_READ || state_q == S_DONE);

`ifdef ABSENC_TIMEOUT_EN
  logic tmo_q, tmo_d, tmo_set;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dev_d      = dev_q;
    ch_d       = ch_q;
    ph_d       = ph_q;
    shadow_d   = shadow_q;
    data_out_d = data_out_q;
    fv_d       = 1'b0;
    fcnt_d     = fcnt_q;
`ifdef ABSENC_TIMEOUT_EN
    tmo_set    = 1'b0;
`endif
    case (state_q)
      S_RST_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (trig_rise) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(CONV_LOW - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (busy_fall) begin
          state_d = S_READ;
          cnt_d   = '0;
          dev_d   = '0;
          ch_d    = '0;
          ph_d    = 1'b0;
        end
`ifdef ABSENC_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tmo_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_READ: begin
        if (!ph_q) begin
          if (cnt_q == CNT_W'(CS_LOW - 1)) begin
            shadow_d[int'(k)*DATA_W +: DATA_W] = data_in;
            ph_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == CNT_W'(CS_HIGH - 1)) begin
          cnt_d = '0;
          ph_d  = 1'b0;
          if (last_word) begin
            // publish on DONE entry so strobe, data and count change together
            state_d    = S_DONE;
            data_out_d = shadow_q;
            fv_d       = 1'b1;
            fcnt_d     = fcnt_q + 1'b1;
          end else if (ch_q == CH_W'(CH_PER_DEV - 1)) begin
            ch_d  = '0;
            dev_d = dev_q + 1'b1;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_RST_HOLD;
    endcase

    ovr_d = ovr_q;
    if (clr_err) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
`ifdef ABSENC_TIMEOUT_EN
    tmo_d = tmo_q;
    if (clr_err) tmo_d = 1'b0;
    if (tmo_set) tmo_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= '0;
      dev_q       <= '0;
      ch_q        <= '0;
      ph_q        <= 1'b0;
      shadow_q    <= '0;
      data_out_q  <= '0;
      fv_q        <= 1'b0;
      fcnt_q      <= '0;
      ovr_q       <= 1'b0;
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
      busy_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dev_q       <= dev_d;
      ch_q        <= ch_d;
      ph_q        <= ph_d;
      shadow_q    <= shadow_d;
      data_out_q  <= data_out_d;
      fv_q        <= fv_d;
      fcnt_q      <= fcnt_d;
      ovr_q       <= ovr_d;
      trig_meta_q <= trig;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
      busy_meta_q <= busy;
      busy_sync_q <= busy_meta_q;
      busy_prev_q <= busy_sync_q;
    end
  end

`ifdef ABSENC_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    cs_n = '1;
    if (state_q == S_READ && !ph_q) cs_n[dev_q] = 1'b0;
  end

  assign enc_rst     = (state_q == S_RST_HOLD);
  assign convst      = (state_q != S_CONV);
  assign rd_active   = (state_q == S_CONV) || (state_q == S_WAIT) || (state_q == S_READ);
  assign data_out    = data_out_q;
  assign frame_valid = fv_q;
  assign frame_cnt   = fcnt_q;
  assign overrun     = ovr_q;

endmodule

// File: doc/abs_encoder_multi.md
Name: abs_encoder_multi

Overview:
- Parametrised successor of the dual-chip, 16-channel absolute-encoder ADC reader.
- Drives NUM_DEV parallel-bus ADCs (AD7606-class) sharing one CONVST, one reset line and one BUSY line; each device has its own CS.
- Samples a frame on each rising edge of the read-trigger, then reads CH_PER_DEV words per device.
- Publishes the whole frame atomically with a valid strobe, frame counter and error flags, for the DSP bridge.

Parameters:
NUM_DEV, 2, number of ADC devices (1..4)
CH_PER_DEV, 8, channels read per device (1..16)
DATA_W, 16, ADC word width
RST_CYC, 8, enc_rst high cycles after reset release (>=2)
CONV_LOW, 5, convst low width in cycles (>=1)
CS_LOW, 1, cs_n low cycles per word (>=1)
CS_HIGH, 1, cs_n high cycles between words (>=1)
TIMEOUT_CYC, 4096, BUSY wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trig  in  1  read request, asynchronous to clk; a rising edge starts a frame
busy  in  1  shared ADC BUSY, asynchronous
data_in  in  DATA_W  ADC parallel data bus
clr_err  in  1  synchronous clear for overrun and err_timeout
convst  out  1  conversion start, active low
enc_rst  out  1  ADC reset, active high
cs_n  out  NUM_DEV  per-device chip select, active low
data_out  out  NUM_DEV*CH_PER_DEV*DATA_W  packed frame; word k = dev*CH_PER_DEV+ch at bits [k*DATA_W +: DATA_W]
frame_valid  out  1  one-cycle pulse when data_out updates
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
overrun  out  1  sticky: trigger edge arrived while not in IDLE
err_timeout  out  1  sticky: BUSY timeout (tied 0 without the optional feature)
rd_active  out  1  high in CONV, WAIT, READ

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - enc_rst=1, convst=1, cs_n all 1.
  - data_out=0, frame_valid=0, frame_cnt=0, overrun=0, err_timeout=0, rd_active=0.
  - FSM in RST_HOLD; all counters 0.
- Synchronisers: trig and busy each pass through a 2-flop synchroniser. Edge detect is on the synchronised signals (rise = q1&~q2, fall = ~q1&q2).
- RST_HOLD: enc_rst=1 for RST_CYC cycles, then enc_rst=0 -> IDLE. Trigger edges are ignored here and overrun is not set.
- IDLE: a trig rise -> CONV. convst goes low on the next clk edge.
- CONV: convst low exactly CONV_LOW cycles, then high -> WAIT.
- WAIT: a synchronised busy falling edge -> READ. A busy fall already pending in the CONV cycle is not used; only falls seen in WAIT count.
- READ:
  - Word order is dev 0 ch 0..CH_PER_DEV-1, then dev 1, and so on.
  - Per word: cs_n[dev] low for CS_LOW cycles; data_in is registered into a shadow buffer on the last low cycle; cs_n then high for CS_HIGH cycles.
  - Only one cs_n bit is low at any time.
  - After the last word's high phase -> DONE.
- DONE (1 cycle):
  - shadow copied to data_out; frame_valid=1; frame_cnt+1.
  - Back to IDLE.
  - data_out never shows a partial frame.
- Overrun: a trig rise in CONV/WAIT/READ/DONE is dropped and sets overrun=1. The frame in progress continues unaffected.
- clr_err=1 clears overrun and err_timeout the next cycle. If a new error event occurs in the same cycle, the set wins.
- Reset mid-frame returns all outputs to reset values immediately. The shadow buffer is discarded and the RST_HOLD sequence reruns.
- Frame length in READ is NUM_DEV*CH_PER_DEV*(CS_LOW+CS_HIGH) cycles.

Optional Feature:
- Macro: ABSENC_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles; reaching TIMEOUT_CYC without a busy fall sets err_timeout=1 and returns to IDLE.
  - No frame_valid; data_out and frame_cnt unchanged.
  - The counter clears on entry to WAIT.
- Undefined: no counter is built; WAIT waits indefinitely; err_timeout is tied 0.

Test Plan:
- Release rst_n -> enc_rst high exactly 8 cycles then 0; convst=1, cs_n=2'b11, data_out=0 throughout.
- ADC model (BUSY high 20 cycles after convst rise, data_in = 0xA000+word index), one trig pulse:
  - convst low 5 cycles;
  - 16 cs pulses, dev0 then dev1;
  - data_out word k = 0xA000+k;
  - single frame_valid; frame_cnt=1.
- Second trig rise 10 cycles into READ -> overrun=1; only one frame_valid; clr_err then gives overrun=0.
- ABSENC_TIMEOUT_EN, TIMEOUT_CYC=64, busy held low (no fall) -> err_timeout=1 after 64 WAIT cycles; no frame_valid; data_out keeps the prior frame.
- rst_n asserted during READ word 5 -> all outputs at reset values the same cycle; next frame reads cleanly.
- NUM_DEV=1, CH_PER_DEV=4, CS_LOW=2, CS_HIGH=3 -> 4 cs_n pulses, each 2 low / 3 high; READ lasts 20 cycles; 64-bit data_out correct.
